// File: rtl/serial_rx_param.sv
// serial_rx_param: parametrised asynchronous serial receiver.
//
// Deserialises an idle-high, LSB-first frame: one start bit, DATA_W data bits,
// an optional parity bit and one stop bit. The serial pin is synchronised with
// two flops, and every decision uses the synchronised bit. Each completed word
// is presented with a one-cycle strobe and error flags.
//
// Parameters:
//   DATA_W       data bits per frame (1..16)
//   CLKS_PER_BIT clk cycles per bit period (>= 4, even)
//   PARITY_EN    1 = a parity bit follows the data bits
//   PARITY_ODD   1 = odd parity, 0 = even parity (ignored if PARITY_EN = 0)
//
// Ports:
//   clk         system clock
//   Reset       asynchronous active-low reset
//   Enable      receiver runs while Enable = 1 and Disable = 0
//   Disable     overrides Enable and aborts any frame in progress
//   Data_In     serial line, asynchronous to clk, idle high
//   Data_Out    last good word, held until the next good word
//   Data_Valid  one-cycle pulse when Data_Out updates
//   Parity_Err  one-cycle pulse, coincident with Data_Valid, on parity mismatch
//   Frame_Err   one-cycle pulse when the stop bit samples low
//   Busy        high whenever the receiver is not idle

module serial_rx_param #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              Enable,
  input  logic              Disable,
  input  logic              Data_In,
  output logic [DATA_W-1:0] Data_Out,
  output logic              Data_Valid,
  output logic              Parity_Err,
  output logic              Frame_Err,
  output logic              Busy
);

  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW  = $clog2(DATA_W + 1);

  // Mid-bit point used to qualify the start bit; every later sample is a full
  // bit period after the previous one, so it also lands mid-bit.
  localparam logic [BaudW-1:0] BaudMid = BaudW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BaudW-1:0] BaudEnd = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0]  LastBit = BitW'(DATA_W - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } state_e;

  state_e              state_q;
  logic                sync1_q;
  logic                sync2_q;
  logic                rx_s;
  logic                active;
  logic [BaudW-1:0]    baud_q;
  logic [BitW-1:0]     bit_q;
  logic [DATA_W-1:0]   shift_q;
  logic [DATA_W-1:0]   shift_nxt;
  logic                perr_q;
  logic [DATA_W-1:0]   data_q;
  logic                valid_q;
  logic                perr_out_q;
  logic                ferr_q;

  // Two-flop synchroniser; preset to the idle (high) line level.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= Data_In;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s   = sync2_q;
  assign active = Enable & ~Disable;

  // New bit enters at the MSB and the word shifts right, so after DATA_W
  // samples the first-received bit sits in bit 0. Written as a shift of the
  // concatenation so it also holds for DATA_W = 1.
  assign shift_nxt = DATA_W'({rx_s, shift_q} >> 1);

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= StIdle;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_q     <= 1'b0;

      if (!active) begin
        // Abort: drop the frame, keep Data_Out, issue nothing.
        state_q <= StIdle;
        baud_q  <= '0;
        bit_q   <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            baud_q <= '0;
            bit_q  <= '0;
            if (!rx_s) begin
              state_q <= StStart;
            end
          end

          StStart: begin
            if (baud_q == BaudMid) begin
              baud_q <= '0;
              bit_q  <= '0;
              // A line that is high again at mid-bit was only a glitch.
              state_q <= rx_s ? StIdle : StData;
            end else begin
              baud_q <= baud_q + 1'b1;
            end
          end

          StData: begin
            if (baud_q == BaudEnd) begin
              baud_q  <= '0;
              shift_q <= shift_nxt;
              bit_q   <= bit_q + 1'b1;
              if (bit_q == LastBit) begin
                state_q <= PARITY_EN ? StParity : StStop;
              end
            end else begin
              baud_q <= baud_q + 1'b1;
            end
          end

          StParity: begin
            if (baud_q == BaudEnd) begin
              baud_q  <= '0;
              // Even parity: data XOR parity bit must be 0; odd flips that.
              perr_q  <= (^shift_q) ^ rx_s ^ PARITY_ODD;
              state_q <= StStop;
            end else begin
              baud_q <= baud_q + 1'b1;
            end
          end

          StStop: begin
            if (baud_q == BaudEnd) begin
              baud_q <= '0;
              if (rx_s) begin
                data_q     <= shift_q;
                valid_q    <= 1'b1;
                perr_out_q <= PARITY_EN & perr_q;
                state_q    <= StIdle;
              end else begin
                ferr_q  <= 1'b1;
                state_q <= StBreak;
              end
            end else begin
              baud_q <= baud_q + 1'b1;
            end
          end

          StBreak: begin
            // Hold off new starts until the line returns high.
            if (rx_s) begin
              state_q <= StIdle;
            end
          end

          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign Data_Out   = data_q;
  assign Data_Valid = valid_q;
  assign Parity_Err = perr_out_q;
  assign Frame_Err  = ferr_q;
  assign Busy       = (state_q != StIdle);

endmodule
